// File: rtl/jelly2_wb_gpio_pkg.sv
// Shared register map for the jelly2 Wishbone GPIO peripheral.
package jelly2_wb_gpio_pkg;

  localparam int ADR_OUT     = 0;
  localparam int ADR_SET     = 1;
  localparam int ADR_CLR     = 2;
  localparam int ADR_DIR     = 3;
  localparam int ADR_IN      = 4;
  localparam int ADR_RISE_EN = 5;
  localparam int ADR_FALL_EN = 6;
  localparam int ADR_STATUS  = 7;

  localparam int REG_NUM     = 8;

endpackage

// File: rtl/jelly2_gpio_input_sync.sv
// Pin input synchroniser with history flop and edge detection, gated until
// the synchroniser has been refilled after reset.
module jelly2_gpio_input_sync #(
  parameter int NUM         = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic           resetn,
  input  logic           clk,
  input  logic           cke,
  input  logic [NUM-1:0] gpio_i,
  output logic [NUM-1:0] sync_val,
  output logic [NUM-1:0] rise,
  output logic [NUM-1:0] fall
);

  localparam logic [2:0] PRIME_MAX = 3'(SYNC_STAGES + 1);

  logic [NUM-1:0] sync_p [SYNC_STAGES];
  logic [NUM-1:0] hist_p;
  logic [2:0]     prime_cnt;
  logic           primed;

  assign primed = (prime_cnt == PRIME_MAX);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_p[k] <= '0;
      end
      hist_p    <= '0;
      prime_cnt <= '0;
    end else if (cke) begin
      sync_p[0] <= gpio_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_p[k] <= sync_p[k-1];
      end
      hist_p <= sync_p[SYNC_STAGES-1];
      if (!primed) begin
        prime_cnt <= prime_cnt + 3'd1;
      end
    end
  end

  // Edges only count once zeros flushed in by reset have left the chain.
  assign sync_val = sync_p[SYNC_STAGES-1];
  assign rise     = primed ? ( sync_val & ~hist_p) : '0;
  assign fall     = primed ? (~sync_val &  hist_p) : '0;

endmodule

// File: rtl/jelly2_wb_gpio.sv
// Wishbone GPIO: output/direction registers with atomic set/clear,
// synchronised input readback and edge interrupts with W1C status.
module jelly2_wb_gpio
  import jelly2_wb_gpio_pkg::*;
#(
  parameter int             NUM          = 8,
  parameter int             WB_ADR_WIDTH = 3,
  parameter int             WB_DAT_WIDTH = 32,
  parameter int             WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
  parameter int             SYNC_STAGES  = 2,
  parameter logic [NUM-1:0] INIT_OUT     = '0,
  parameter logic [NUM-1:0] INIT_DIR     = '0
) (
  input  logic                    resetn,
  input  logic                    clk,
  input  logic                    cke,
  input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
  input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
  input  logic                    s_wb_we_i,
  input  logic                    s_wb_stb_i,
  output logic                    s_wb_ack_o,
  input  logic [NUM-1:0]          gpio_i,
  output logic [NUM-1:0]          gpio_o,
  output logic [NUM-1:0]          gpio_oe,
  output logic                    irq
);

  function automatic logic [NUM-1:0] lane_mask(input logic [WB_SEL_WIDTH-1:0] sel);
    logic [NUM-1:0] m;
    for (int i = 0; i < NUM; i++) begin
      m[i] = sel[i/8];
    end
    return m;
  endfunction

  function automatic logic [NUM-1:0] merge(input logic [NUM-1:0] old_val,
                                           input logic [NUM-1:0] new_val,
                                           input logic [NUM-1:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  logic [NUM-1:0] out_reg, dir_reg, rise_en, fall_en, status, status_next;
  logic [NUM-1:0] in_val, rise, fall;
  logic [NUM-1:0] wdat, wmask, clr_bits, rdata;
  logic [31:0]    adr;
  logic           wr;
  logic           unused_bits;

  jelly2_gpio_input_sync #(
    .NUM         (NUM),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_input_sync (
    .resetn   (resetn),
    .clk      (clk),
    .cke      (cke),
    .gpio_i   (gpio_i),
    .sync_val (in_val),
    .rise     (rise),
    .fall     (fall)
  );

  // Full address is decoded so that out-of-map words never alias registers.
  assign adr         = 32'(s_wb_adr_i);
  assign wr          = s_wb_stb_i & s_wb_we_i & cke;
  assign wdat        = s_wb_dat_i[NUM-1:0];
  assign wmask       = lane_mask(s_wb_sel_i);
  assign unused_bits = ^{s_wb_dat_i, s_wb_sel_i};

  assign s_wb_ack_o  = s_wb_stb_i & cke;

  // A new edge wins over a simultaneous clear so no event is ever lost.
  assign clr_bits    = (wr && adr == ADR_STATUS) ? (wdat & wmask) : '0;
  assign status_next = (status & ~clr_bits) | (rise & rise_en) | (fall & fall_en);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_reg <= INIT_OUT;
      dir_reg <= INIT_DIR;
      rise_en <= '0;
      fall_en <= '0;
      status  <= '0;
    end else if (cke) begin
      if (wr && adr == ADR_OUT)     out_reg <= merge(out_reg, wdat, wmask);
      if (wr && adr == ADR_SET)     out_reg <= out_reg | (wdat & wmask);
      if (wr && adr == ADR_CLR)     out_reg <= out_reg & ~(wdat & wmask);
      if (wr && adr == ADR_DIR)     dir_reg <= merge(dir_reg, wdat, wmask);
      if (wr && adr == ADR_RISE_EN) rise_en <= merge(rise_en, wdat, wmask);
      if (wr && adr == ADR_FALL_EN) fall_en <= merge(fall_en, wdat, wmask);
      status <= status_next;
    end
  end

  always_comb begin
    rdata      = '0;
    s_wb_dat_o = '0;
    case (adr)
      ADR_OUT:     rdata = out_reg;
      ADR_DIR:     rdata = dir_reg;
      ADR_IN:      rdata = in_val;
      ADR_RISE_EN: rdata = rise_en;
      ADR_FALL_EN: rdata = fall_en;
      ADR_STATUS:  rdata = status;
      default:     rdata = '0;
    endcase
    s_wb_dat_o[NUM-1:0] = rdata;
  end

  assign gpio_o  = out_reg;
  assign gpio_oe = dir_reg;
  assign irq     = |status;

endmodule

// File: tb/tb_jelly2_wb_gpio.sv
// Scoreboard bench for jelly2_wb_gpio: stimulus queues expectations, a
// negedge monitor compares read data on ack and queued pin samples.
module tb_jelly2_wb_gpio;

  localparam logic [3:0] A_OUT = 4'd0, A_SET = 4'd1, A_CLR = 4'd2, A_DIR = 4'd3;
  localparam logic [3:0] A_IN = 4'd4, A_RISE = 4'd5, A_FALL = 4'd6, A_STAT = 4'd7;

  localparam int S_GPIO_O = 0, S_GPIO_OE = 1, S_IRQ = 2, S_ACK = 3, S_DRAIN = 4;

  logic        clk, resetn, cke;
  logic [3:0]  adr;
  logic [31:0] dat_i, dat_o;
  logic [3:0]  sel;
  logic        we, stb, ack;
  logic [7:0]  gpio_i, gpio_o, gpio_oe;
  logic        irq;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } rd_t;

  typedef struct {
    int          sig;
    logic [31:0] exp;
    string       name;
  } pin_t;

  rd_t  rd_q[$];
  pin_t pin_q[$];
  int   checks = 0;
  int   failures = 0;

  jelly2_wb_gpio #(
    .NUM          (8),
    .WB_ADR_WIDTH (4),
    .WB_DAT_WIDTH (32),
    .WB_SEL_WIDTH (4),
    .SYNC_STAGES  (2),
    .INIT_OUT     (8'hA5),
    .INIT_DIR     (8'h0F)
  ) dut (
    .resetn     (resetn),
    .clk        (clk),
    .cke        (cke),
    .s_wb_adr_i (adr),
    .s_wb_dat_i (dat_i),
    .s_wb_dat_o (dat_o),
    .s_wb_sel_i (sel),
    .s_wb_we_i  (we),
    .s_wb_stb_i (stb),
    .s_wb_ack_o (ack),
    .gpio_i     (gpio_i),
    .gpio_o     (gpio_o),
    .gpio_oe    (gpio_oe),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: sole owner of the check/failure counters.
  rd_t         mon_r;
  pin_t        mon_p;
  logic [31:0] mon_act;

  always begin
    @(negedge clk);
    if (ack && !we) begin
      checks++;
      if (rd_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read_ack got=%h required=no_ack", dat_o);
      end else begin
        mon_r = rd_q.pop_front();
        if (dat_o !== mon_r.exp) begin
          failures++;
          $display("FAIL %s got=%h required=%h", mon_r.name, dat_o, mon_r.exp);
        end
      end
    end
    while (pin_q.size() > 0) begin
      mon_p = pin_q.pop_front();
      case (mon_p.sig)
        S_GPIO_O:  mon_act = {24'b0, gpio_o};
        S_GPIO_OE: mon_act = {24'b0, gpio_oe};
        S_IRQ:     mon_act = {31'b0, irq};
        S_ACK:     mon_act = {31'b0, ack};
        S_DRAIN:   mon_act = 32'(rd_q.size());
        default:   mon_act = '1;
      endcase
      checks++;
      if (mon_act !== mon_p.exp) begin
        failures++;
        $display("FAIL %s got=%h required=%h", mon_p.name, mon_act, mon_p.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input int s, input logic [31:0] e, input string n);
    pin_t t;
    t.sig  = s;
    t.exp  = e;
    t.name = n;
    pin_q.push_back(t);
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    adr   = a;
    dat_i = d;
    sel   = s;
    we    = 1'b1;
    stb   = 1'b1;
    tick();
    stb   = 1'b0;
    we    = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a, input logic [31:0] e, input string n);
    rd_t t;
    t.exp  = e;
    t.name = n;
    rd_q.push_back(t);
    adr = a;
    sel = 4'hF;
    we  = 1'b0;
    stb = 1'b1;
    tick();
    stb = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; cke = 1'b1; adr = '0; dat_i = '0; sel = '0;
    we = 1'b0; stb = 1'b0; gpio_i = 8'hFF;
    repeat (3) tick();
    pin(S_GPIO_O, 32'hA5, "reset_gpio_o");
    pin(S_GPIO_OE, 32'h0F, "reset_gpio_oe");
    pin(S_IRQ, 32'h0, "reset_irq");
    tick();

    // Release with pins high and rise enabled at once: priming must hide it.
    resetn = 1'b1;
    bus_wr(A_RISE, 32'hFF, 4'hF);
    for (int i = 0; i < 20; i++) begin
      pin(S_IRQ, 32'h0, "prime_irq");
      tick();
    end
    bus_wr(A_RISE, 32'h00, 4'hF);
    bus_rd(A_STAT, 32'h00, "prime_status");
    bus_rd(A_IN, 32'hFF, "in_all_high");

    // OUT / SET / CLR back-to-back
    bus_wr(A_OUT, 32'h00, 4'hF);
    pin(S_GPIO_O, 32'h00, "out_write");
    bus_wr(A_SET, 32'h81, 4'hF);
    pin(S_GPIO_O, 32'h81, "out_set");
    bus_wr(A_CLR, 32'h01, 4'hF);
    pin(S_GPIO_O, 32'h80, "out_clr");
    bus_rd(A_SET, 32'h00, "set_reads_zero");
    bus_rd(A_CLR, 32'h00, "clr_reads_zero");
    bus_rd(A_OUT, 32'h80, "out_readback");

    // Byte-lane enables on DIR
    bus_wr(A_DIR, 32'h1234_56FF, 4'b0001);
    pin(S_GPIO_OE, 32'hFF, "dir_lane0");
    bus_rd(A_DIR, 32'hFF, "dir_readback");
    bus_wr(A_DIR, 32'h0000_0000, 4'b0000);
    pin(S_GPIO_OE, 32'hFF, "dir_sel_none");
    bus_wr(A_DIR, 32'h0000_0000, 4'b1110);
    bus_rd(A_DIR, 32'hFF, "dir_upper_lanes");

    // Rising edge on bit 0
    gpio_i = 8'h00;
    repeat (5) tick();
    bus_wr(A_RISE, 32'h01, 4'hF);
    gpio_i = 8'h01;
    tick();
    pin(S_IRQ, 32'h0, "rise_irq_1clk");
    bus_rd(A_IN, 32'h00, "in_after_1clk");
    pin(S_IRQ, 32'h0, "rise_irq_2clk");
    bus_rd(A_IN, 32'h01, "in_after_2clk");
    pin(S_IRQ, 32'h1, "rise_irq_3clk");
    bus_rd(A_STAT, 32'h01, "rise_status");
    bus_wr(A_STAT, 32'h01, 4'hF);
    pin(S_IRQ, 32'h0, "w1c_irq");
    bus_rd(A_STAT, 32'h00, "w1c_status");

    // Falling edge on bit 1 coinciding with its W1C
    bus_wr(A_FALL, 32'h02, 4'hF);
    gpio_i = 8'h03;
    repeat (5) tick();
    bus_rd(A_STAT, 32'h00, "rise1_not_enabled");
    gpio_i = 8'h01;
    tick();
    tick();
    bus_wr(A_STAT, 32'h02, 4'hF);
    pin(S_IRQ, 32'h1, "set_wins_irq");
    bus_rd(A_STAT, 32'h02, "set_wins_status");
    bus_wr(A_STAT, 32'h02, 4'hF);
    pin(S_IRQ, 32'h0, "fall_cleared_irq");
    bus_rd(A_STAT, 32'h00, "fall_cleared_status");

    // Clock enable low: no ack, no state change
    bus_wr(A_RISE, 32'hFF, 4'hF);
    bus_wr(A_FALL, 32'hFF, 4'hF);
    tick();
    cke = 1'b0; adr = A_OUT; dat_i = 32'hFF; sel = 4'hF; we = 1'b1; stb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      gpio_i = (i % 2 == 0) ? 8'hFE : 8'h01;
      pin(S_ACK, 32'h0, "ack_cke_low");
      tick();
    end
    gpio_i = 8'h01;
    stb = 1'b0; we = 1'b0; cke = 1'b1;
    bus_rd(A_OUT, 32'h80, "out_held_cke");
    pin(S_IRQ, 32'h0, "irq_held_cke");
    bus_rd(A_STAT, 32'h00, "status_held_cke");
    tick();
    bus_rd(A_STAT, 32'h00, "status_after_cke");

    // Out-of-map address
    bus_rd(4'd9, 32'h00, "adr9_read");
    bus_wr(4'd9, 32'hFF, 4'hF);
    bus_rd(A_OUT, 32'h80, "adr9_write_ignored");

    // Reset during a write: acked, discarded, registers restored
    adr = A_OUT; dat_i = 32'h00; sel = 4'hF; we = 1'b1; stb = 1'b1; resetn = 1'b0;
    pin(S_ACK, 32'h1, "ack_in_reset");
    tick();
    stb = 1'b0; we = 1'b0; resetn = 1'b1;
    pin(S_GPIO_O, 32'hA5, "out_after_reset");
    pin(S_GPIO_OE, 32'h0F, "dir_after_reset");
    tick();

    pin(S_DRAIN, 32'h0, "scoreboard_drained");
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
